// File: rtl/panel_pkg.sv
// ----------------------------------------------------------------------------
// | Module   : panel_pkg                                                     |
// | Desc     : Shared FSM state codes, switch event indices and helpers      |
// |            for the front panel controller.                               |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
`default_nettype none

package panel_pkg;

  localparam int c_NUM_SW = 5;

  typedef enum logic [2:0] {
    ST_CLEARING = 3'd0,
    ST_HALTED   = 3'd1,
    ST_RUNNING  = 3'd2,
    ST_STOPPING = 3'd3,
    ST_STEPM    = 3'd4,
    ST_STEPI    = 3'd5
  } state_e;

  // Index order doubles as event priority: lowest index wins.
  typedef enum logic [2:0] {
    SW_CLEAR = 3'd0,
    SW_HALT  = 3'd1,
    SW_RUN   = 3'd2,
    SW_STEPI = 3'd3,
    SW_STEPM = 3'd4
  } sw_idx_e;

  function automatic logic [c_NUM_SW-1:0] pick_event(input logic [c_NUM_SW-1:0] ev);
    pick_event = '0;
    for (int i = c_NUM_SW - 1; i >= 0; i--) begin
      if (ev[i]) begin
        pick_event    = '0;
        pick_event[i] = 1'b1;
      end
    end
  endfunction

  function automatic logic state_advances(input state_e s);
    return (s == ST_RUNNING) || (s == ST_STOPPING) ||
           (s == ST_STEPM)   || (s == ST_STEPI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/panel_debounce.sv
// ----------------------------------------------------------------------------
// | Module   : panel_debounce                                                |
// | Desc     : Two-flop synchronizer, stability counter, debounced level and |
// |            one-cycle press pulse for a single panel switch.              |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
`default_nettype none

module panel_debounce
  import panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw_i,
  output logic press_o
);

  localparam logic [7:0] c_CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync_q;
  logic [1:0] fill_q;
  logic [7:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       suppress_q, suppress_d;

  always_comb begin
    cnt_d      = cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    suppress_d = suppress_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == c_CNT_LAST) begin
      cnt_d   = '0;
      level_d = sync_q[1];
      if (sync_q[1]) begin
        press_d    = ~suppress_q;
        suppress_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    // Once the synchronizer holds a real sample, a released switch disarms
    // the suppression meant for switches held down across reset.
    if (fill_q[1] && !sync_q[1]) begin
      suppress_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      fill_q     <= '0;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      suppress_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], sw_raw_i};
      fill_q     <= {fill_q[0], 1'b1};
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      suppress_q <= suppress_d;
    end
  end

  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/front_panel_ctrl.sv
// ----------------------------------------------------------------------------
// | Module   : front_panel_ctrl                                              |
// | Desc     : Debounced front-panel switches driving a run/halt/step FSM    |
// |            for the CPU. FRONT_PANEL_AUTORUN_EN: start running after      |
// |            power-on reset instead of halting.                            |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
`default_nettype none

module front_panel_ctrl
  import panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CLEAR_CYCLES    = 8
) (
  input  logic       SYSCLK,
  input  logic       RESET,
  input  logic       sw_CLEAR,
  input  logic       sw_RUN,
  input  logic       sw_HALT,
  input  logic       sw_STEPM,
  input  logic       sw_STEPI,
  input  logic       cycleDone,
  input  logic       instDone,
  input  logic       cpuHalt,
  output logic       cpuClear,
  output logic       cpuAdvance,
  output logic       ledRun,
  output logic [2:0] state
);

  localparam logic [7:0] c_CLR_LAST = 8'(CLEAR_CYCLES - 1);

  logic [c_NUM_SW-1:0] sw_raw;
  logic [c_NUM_SW-1:0] sw_press;
  logic [c_NUM_SW-1:0] ev_sel;

  state_e     state_q, state_d;
  state_e     exit_state;
  logic [7:0] clr_cnt_q, clr_cnt_d;
  logic       cpuClear_q, cpuAdvance_q, ledRun_q;

  assign sw_raw[SW_CLEAR] = sw_CLEAR;
  assign sw_raw[SW_HALT]  = sw_HALT;
  assign sw_raw[SW_RUN]   = sw_RUN;
  assign sw_raw[SW_STEPI] = sw_STEPI;
  assign sw_raw[SW_STEPM] = sw_STEPM;

  for (genvar g = 0; g < c_NUM_SW; g++) begin : g_sw
    panel_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (SYSCLK),
      .rst      (RESET),
      .sw_raw_i (sw_raw[g]),
      .press_o  (sw_press[g])
    );
  end

  assign ev_sel = pick_event(sw_press);

`ifdef FRONT_PANEL_AUTORUN_EN
  // Set only by reset; any panel CLEAR makes the clear sequence end halted.
  logic autorun_q;

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      autorun_q <= 1'b1;
    end else if (ev_sel[SW_CLEAR]) begin
      autorun_q <= 1'b0;
    end
  end

  assign exit_state = autorun_q ? ST_RUNNING : ST_HALTED;
`else
  assign exit_state = ST_HALTED;
`endif

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (ev_sel[SW_CLEAR]) begin
      state_d   = ST_CLEARING;
      clr_cnt_d = '0;
    end else begin
      case (state_q)
        ST_CLEARING: begin
          if (clr_cnt_q == c_CLR_LAST) begin
            state_d   = exit_state;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 8'd1;
          end
        end
        ST_HALTED: begin
          if (ev_sel[SW_RUN]) begin
            state_d = ST_RUNNING;
          end else if (ev_sel[SW_STEPI]) begin
            state_d = ST_STEPI;
          end else if (ev_sel[SW_STEPM]) begin
            state_d = ST_STEPM;
          end
        end
        ST_RUNNING: begin
          if (cpuHalt) begin
            state_d = ST_HALTED;
          end else if (ev_sel[SW_HALT]) begin
            state_d = ST_STOPPING;
          end
        end
        ST_STOPPING: begin
          // Stop only on an instruction boundary.
          if (instDone || cpuHalt) begin
            state_d = ST_HALTED;
          end else if (ev_sel[SW_RUN]) begin
            state_d = ST_RUNNING;
          end
        end
        ST_STEPM: begin
          if (cycleDone || cpuHalt) begin
            state_d = ST_HALTED;
          end
        end
        ST_STEPI: begin
          if (instDone || cpuHalt) begin
            state_d = ST_HALTED;
          end
        end
        default: begin
          state_d   = ST_CLEARING;
          clr_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state_q      <= ST_CLEARING;
      clr_cnt_q    <= '0;
      cpuClear_q   <= 1'b1;
      cpuAdvance_q <= 1'b0;
      ledRun_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      cpuClear_q   <= (state_d == ST_CLEARING);
      cpuAdvance_q <= state_advances(state_d);
      ledRun_q     <= (state_d == ST_RUNNING) || (state_d == ST_STOPPING);
    end
  end

  assign cpuClear   = cpuClear_q;
  assign cpuAdvance = cpuAdvance_q;
  assign ledRun     = ledRun_q;
  assign state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_front_panel_ctrl.sv
// ----------------------------------------------------------------------------
// | Module   : tb_front_panel_ctrl                                           |
// | Desc     : Directed self-checking bench for front_panel_ctrl.            |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_front_panel_ctrl;

  logic       SYSCLK = 1'b0;
  logic       rst    = 1'b1;
  logic [4:0] sw     = '0;   // 0 CLEAR, 1 HALT, 2 RUN, 3 STEPI, 4 STEPM
  logic       cd = 1'b0, id = 1'b0, ch = 1'b0;
  logic       clr_o, adv_o, led_o;
  logic [2:0] st_o;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef FRONT_PANEL_AUTORUN_EN
  localparam int c_EXIT = 2;
`else
  localparam int c_EXIT = 1;
`endif

  always #5 SYSCLK = ~SYSCLK;

  front_panel_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CLEAR_CYCLES   (8)
  ) dut (
    .SYSCLK     (SYSCLK),
    .RESET      (rst),
    .sw_CLEAR   (sw[0]),
    .sw_RUN     (sw[2]),
    .sw_HALT    (sw[1]),
    .sw_STEPM   (sw[4]),
    .sw_STEPI   (sw[3]),
    .cycleDone  (cd),
    .instDone   (id),
    .cpuHalt    (ch),
    .cpuClear   (clr_o),
    .cpuAdvance (adv_o),
    .ledRun     (led_o),
    .state      (st_o)
  );

  typedef struct {
    logic       rst;
    logic [4:0] sw;
    logic       cd, id, ch;
    int         st;
    int         outs;  // {clr, adv, led}
  } vec_t;

  vec_t tbl[$];

  // Expected {cpuClear, cpuAdvance, ledRun} for a given state code.
  function automatic int outs_for(input int s);
    int c, a, l;
    c = (s == 0) ? 1 : 0;
    a = (s >= 2 && s <= 5) ? 1 : 0;
    l = (s == 2 || s == 3) ? 1 : 0;
    return c * 4 + a * 2 + l;
  endfunction

  task automatic add(input logic r, input logic [4:0] s, input logic c, input logic i,
                     input logic h, input int exp_st);
    vec_t v;
    v.rst = r; v.sw = s; v.cd = c; v.id = i; v.ch = h;
    v.st = exp_st; v.outs = outs_for(exp_st);
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse(input int which);
    if (which == 0) cd = 1'b1;
    else if (which == 1) id = 1'b1;
    else ch = 1'b1;
    step();
    cd = 1'b0; id = 1'b0; ch = 1'b0;
  endtask

  // Hold a switch until the FSM reaches exp_st; debounce latency is 2+4+1.
  task automatic press(input int idx, input int exp_st, input string nm);
    int n;
    n = 0;
    sw[idx] = 1'b1;
    while (int'(st_o) != exp_st && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_latency"}, n, 7);
  endtask

  task automatic release_sw(input int idx);
    sw[idx] = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, cnt;

    // Reset, clear sequence, then bouncing RUN switch.
    add(1, 5'b0, 0, 0, 0, 0);
    add(1, 5'b0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 5'b0, 0, 0, 0, 0);
    add(0, 5'b0, 0, 0, 0, c_EXIT);
`ifdef FRONT_PANEL_AUTORUN_EN
    add(0, 5'b0, 0, 0, 1, 1);
`endif
    add(0, 5'b0, 0, 0, 0, 1);
    add(0, 5'b0, 0, 0, 0, 1);
    add(0, 5'b00100, 0, 0, 0, 1);
    add(0, 5'b00000, 0, 0, 0, 1);
    add(0, 5'b00100, 0, 0, 0, 1);
    add(0, 5'b00000, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) add(0, 5'b00100, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 5'b00100, 0, 0, 0, 2);
    for (int i = 0; i < 8; i++) add(0, 5'b00000, 0, 0, 0, 2);

    foreach (tbl[k]) begin
      rst = tbl[k].rst; sw = tbl[k].sw;
      cd = tbl[k].cd; id = tbl[k].id; ch = tbl[k].ch;
      step();
      chk($sformatf("row%0d", k), {int'(st_o), 3'(outs_for(0) & 0) | 3'({clr_o, adv_o, led_o})} == 0 ? -1 :
          int'(st_o) * 8 + int'({clr_o, adv_o, led_o}), tbl[k].st * 8 + tbl[k].outs);
    end
    cd = 1'b0; id = 1'b0; ch = 1'b0; sw = '0;

    // HALT while running: stop on instruction boundary.
    press(1, 3, "halt");
    for (int i = 0; i < 5; i++) begin
      chk("stop_wait", int'(st_o) * 2 + int'(adv_o), 3 * 2 + 1);
      if (i < 4) step();
    end
    pulse(1);
    chk("stop_done_state", int'(st_o), 1);
    chk("stop_done_adv", int'(adv_o), 0);
    release_sw(1);

    // Single microcycle step.
    press(4, 4, "stepm");
    release_sw(4);
    chk("stepm_hold", int'(st_o) * 2 + int'(adv_o), 4 * 2 + 1);
    pulse(0);
    chk("stepm_done", int'(st_o) * 2 + int'(adv_o), 1 * 2 + 0);

    // Single instruction step ignores cycleDone.
    press(3, 5, "stepi");
    release_sw(3);
    for (int i = 0; i < 3; i++) begin
      pulse(0);
      step();
      chk("stepi_cycle", int'(st_o) * 2 + int'(adv_o), 5 * 2 + 1);
    end
    pulse(1);
    chk("stepi_done", int'(st_o) * 2 + int'(adv_o), 1 * 2 + 0);

    // CPU HLT while running.
    press(2, 2, "run2");
    chk("run2_led", int'(led_o), 1);
    release_sw(2);
    pulse(2);
    chk("cpuhalt_state", int'(st_o), 1);
    chk("cpuhalt_led", int'(led_o), 0);

    // CLEAR and RUN together mid-step: CLEAR wins, RUN dropped.
    press(3, 5, "stepi2");
    release_sw(3);
    sw[0] = 1'b1;
    sw[2] = 1'b1;
    n = 0;
    while (int'(st_o) != 0 && n < 20) begin
      step();
      n++;
    end
    chk("clear_latency", n, 7);
    cnt = (clr_o == 1'b1) ? 1 : 0;
    n = 0;
    while (clr_o == 1'b1 && n < 20) begin
      step();
      n++;
      if (clr_o == 1'b1) cnt++;
    end
    chk("clear_len", cnt, 8);
    chk("clear_exit", int'(st_o), 1);
    sw = '0;
    repeat (10) step();
    chk("clear_run_dropped", int'(st_o), 1);

    // RUN held through reset must not start the machine.
    sw[2] = 1'b1;
    rst = 1'b1;
    repeat (2) step();
    chk("reset_state", int'(st_o) * 8 + int'({clr_o, adv_o, led_o}), 0 * 8 + 4);
    rst = 1'b0;
    repeat (20) step();
    chk("held_run_after_reset", int'(st_o), c_EXIT);
    sw[2] = 1'b0;
    repeat (10) step();
    chk("held_run_released", int'(st_o), c_EXIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/front_panel_ctrl.md
FRONT_PANEL_CTRL -- requirements
Module: front_panel_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples required before a switch level is accepted; legal range 2..255.
REQ-002 Parameter CLEAR_CYCLES, default 8: length of the CPU clear pulse in SYSCLK cycles; legal range 1..255.
REQ-003 SYSCLK  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 sw_CLEAR, sw_RUN, sw_HALT, sw_STEPM, sw_STEPI  in  1 each  raw, asynchronous, bouncing panel switch levels; 1 = pressed.
REQ-006 cycleDone  in  1  CPU pulse: one microcycle completed this clock.
REQ-007 instDone  in  1  CPU pulse: one instruction completed this clock.
REQ-008 cpuHalt  in  1  CPU pulse: HLT instruction executed.
REQ-009 cpuClear  out  1  CPU clear, held high for CLEAR_CYCLES cycles.
REQ-010 cpuAdvance  out  1  enables the CPU to advance microcycles.
REQ-011 ledRun  out  1  high in RUNNING and STOPPING.
REQ-012 state  out  3  current FSM state code, for panel display and debug.

Function
REQ-013 Each switch SHALL pass through a 2-flop synchronizer, then a per-switch counter; the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive equal synchronized samples differing from it.
REQ-014 A press event SHALL be a one-cycle pulse on the 0->1 edge of the debounced level; release edges SHALL generate no events.
REQ-015 Fixed event priority, highest first: CLEAR, HALT, RUN, STEPI, STEPM; at most one event SHALL be acted on per cycle and the others dropped.
REQ-016 States: CLEARING=0, HALTED=1, RUNNING=2, STOPPING=3, STEPM=4, STEPI=5.
REQ-017 CLEARING: cpuClear=1 and cpuAdvance=0 for CLEAR_CYCLES cycles, then -> HALTED; clear events in this state SHALL restart the count.
REQ-018 HALTED: cpuAdvance=0; RUN -> RUNNING, STEPI -> STEPI, STEPM -> STEPM, CLEAR -> CLEARING.
REQ-019 RUNNING: cpuAdvance=1; HALT event -> STOPPING; cpuHalt -> HALTED immediately; CLEAR -> CLEARING.
REQ-020 STOPPING: cpuAdvance=1 until instDone, then -> HALTED on the same edge, so the CPU stops on an instruction boundary; RUN in STOPPING -> RUNNING.
REQ-021 STEPM: cpuAdvance=1 until cycleDone, then -> HALTED.
REQ-022 STEPI: cpuAdvance=1 until instDone, then -> HALTED; cpuHalt in STEPI or STEPM -> HALTED.
REQ-023 CLEAR SHALL pre-empt every state, including mid-step and mid-stop.
REQ-024 All outputs SHALL be registered; a state change SHALL appear on the outputs in the cycle after the event.

Reset
REQ-025 RESET SHALL put the FSM in CLEARING with the clear counter at 0, and SHALL zero all synchronizers, debounce counters and debounced levels.
REQ-026 While RESET=1: cpuClear=1, cpuAdvance=0, ledRun=0, state=0.
REQ-027 A switch held down through reset SHALL NOT generate a press event after reset, because its debounced level starts at 0 and must first debounce to 1; the resulting edge is suppressed for switches already pressed at reset release.

Configuration
REQ-028 Macro FRONT_PANEL_AUTORUN_EN defined: CLEARING after RESET (not after a switch CLEAR) SHALL exit to RUNNING instead of HALTED.
REQ-029 Macro undefined: CLEARING SHALL always exit to HALTED.

Structure
REQ-030 State encodings and the switch event index enum SHALL live in shared package panel_pkg.
REQ-031 The debouncer (synchronizer, counter, level, edge pulse) SHALL be the sub-module panel_debounce, instantiated five times.

Verification
REQ-032 RESET for 2 cycles with DEBOUNCE_CYCLES=4 and CLEAR_CYCLES=8 -> cpuClear high exactly 8 cycles after release, then state=1; with FRONT_PANEL_AUTORUN_EN, state=2.
REQ-033 sw_RUN bouncing 1,0,1,0 then stable 1 -> exactly one RUN event; state=2 at 2+4+1 cycles after stabilization.
REQ-034 In RUNNING, press HALT and pulse instDone 5 cycles later -> state=3 during the wait, cpuAdvance=1 until instDone, then state=1.
REQ-035 In HALTED, press STEPM then pulse cycleDone -> cpuAdvance high until cycleDone, then state=1; press STEPI, give 3 cycleDone then 1 instDone -> HALTED only after instDone.
REQ-036 Press sw_RUN and sw_CLEAR together in STEPI -> CLEARING wins; cpuClear pulses 8 cycles and the RUN event is dropped.
REQ-037 In RUNNING, pulse cpuHalt -> state=1 the next cycle and ledRun=0.
